uart_tx_cfg: RTL

Parametrised UART transmitter: configurable data width (5–9 bits), optional even/odd parity, and 1 or 2 stop bits. A valid/ready input handshake feeds a one-word holding register, so frames can run back-to-back with no idle gap between them. The block sits between a byte/word source (FIFO, echo logic, command encoder) and the serial `tx` pin, and is the general-purpose replacement for the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_cfg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, transmitter FSM states,
// parity computation and the bit-period divisor.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    // Data narrower than MAX_DATA_BITS is zero-extended, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input uart_parity_e             mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int uart_div(input int fclk, input int baud);
        return fclk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reloads DIV-1 on load or after reaching zero,
// and ticks during the last cycle of every bit period.
module uart_baud_cnt #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= W'(DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/even/odd parity, 1 or 2
// stop bits) with a one-word holding register for gap-free back-to-back frames.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FCLK      = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 idle
);

    localparam int           DIV      = uart_div(FCLK, BAUD);
    localparam int           BCW      = $clog2(DATA_BITS);
    localparam uart_parity_e PAR_MODE = uart_parity_e'(2'(PARITY));

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: FCLK/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_e       state, state_n;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 load_frame;
    logic                 tick;
    logic                 tx_n;
    logic                 handshake;

    assign tx_ready  = ~hold_full;
    assign handshake = tx_valid & tx_ready;
    assign idle      = (state == ST_IDLE) && !hold_full;

    uart_baud_cnt #(
        .DIV (DIV)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load_frame),
        .tick (tick)
    );

    // NOTE: the data word carries no reset; hold_full alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (handshake) begin
            hold <= tx_data;
        end
    end

    // Load and accept never coincide: loading needs hold_full, accepting needs it clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
        end else if (load_frame) begin
            hold_full <= 1'b0;
        end else if (handshake) begin
            hold_full <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        par_n      = par;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        load_frame = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load_frame = 1'b1;
                    state_n    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        state_n    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_n    = ST_STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        if (hold_full) begin
                            load_frame = 1'b1;
                            state_n    = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load_frame) begin
            shreg_n   = hold;
            par_n     = uart_parity(MAX_DATA_BITS'(hold), PAR_MODE);
            bit_cnt_n = '0;
        end

        // tx is registered, so its next value follows the next state.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[bit_cnt_n];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            par      <= par_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            tx       <= tx_n;
        end
    end

endmodule
